stream_arb_mux: RTL

Parametrised successor to the team's select-driven muxes. Merges 2**SEL_WIDTH valid/ready input streams into one registered output stream. Arbitration is round-robin, fixed-priority or external-select, chosen at run time. A grant is held for a whole packet (until a beat with last=1). Sits at the merge point of the packet datapath, ahead of single-consumer sinks.

---
 rtl/stream_arb_mux.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stream_arb_mux.sv
// Merges NUM_CH valid/ready streams into one registered stream; per-packet grant via round-robin, fixed priority or external select.
// Latency: 1 cycle. Backpressure: while out_valid && !out_ready the output holds and every in_ready is low.
module stream_arb_mux #(
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [1:0]                            mode,
    input  logic [SEL_WIDTH-1:0]                  sel,
    input  logic [(1<<SEL_WIDTH)-1:0]             in_valid,
    input  logic [(1<<SEL_WIDTH)-1:0]             in_last,
    input  logic [DATA_WIDTH*(1<<SEL_WIDTH)-1:0]  in_data,
    output logic [(1<<SEL_WIDTH)-1:0]             in_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_last,
    output logic [SEL_WIDTH-1:0]                  out_ch
);

    localparam int NUM_CH = 1 << SEL_WIDTH;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [SEL_WIDTH-1:0]   ptr, ptr_nxt, lock_ch, lock_nxt;
    logic [SEL_WIDTH-1:0]   winner, rr_idx;
    logic                   win_vld, win_last, load_en, xfer;
    logic [DATA_WIDTH-1:0]  win_data;

    assign load_en = !out_valid || out_ready;

    // Descending loops let the last hit (lowest offset / lowest index) win.
    always_comb begin
        winner  = '0;
        win_vld = 1'b0;
        rr_idx  = '0;
        if (state == LOCKED) begin
            winner  = lock_ch;
            win_vld = in_valid[lock_ch];
        end else begin
            case (mode)
                2'd1: begin
                    for (int k = NUM_CH - 1; k >= 0; k--) begin
                        if (in_valid[k]) begin
                            winner  = SEL_WIDTH'(k);
                            win_vld = 1'b1;
                        end
                    end
                end
                2'd2: begin
                    winner  = sel;
                    win_vld = in_valid[sel];
                end
                default: begin
                    for (int k = NUM_CH - 1; k >= 0; k--) begin
                        rr_idx = ptr + SEL_WIDTH'(k);
                        if (in_valid[rr_idx]) begin
                            winner  = rr_idx;
                            win_vld = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (winner == SEL_WIDTH'(i)) begin
                win_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_last = in_last[i];
            end
        end
    end

    // rst_n gating keeps in_ready low during reset even though load_en is high then.
    assign xfer     = load_en && win_vld && rst_n;
    assign in_ready = xfer ? ({{(NUM_CH-1){1'b0}}, 1'b1} << winner) : '0;

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_ch;
        ptr_nxt   = ptr;
        if (xfer) begin
            if (win_last) begin
                state_nxt = IDLE;
                ptr_nxt   = winner + SEL_WIDTH'(1);
            end else begin
                state_nxt = LOCKED;
                lock_nxt  = winner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_ch <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_nxt;
            ptr     <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_last  <= win_last;
            out_ch    <= winner;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
